// File: rtl/jac_isa_pkg.sv
// Instruction-set constants shared by the fetch stage: opcodes, field
// positions, fetch FSM states and the next-pc selector.
package jac_isa_pkg;

   localparam logic [4:0] OP_NOP  = 5'b00000;
   localparam logic [4:0] OP_GOTO = 5'b10000;
   localparam logic [4:0] OP_IFZ  = 5'b10001;
   localparam logic [4:0] OP_IFNZ = 5'b10010;
   localparam logic [4:0] OP_IFEQ = 5'b10011;
   localparam logic [4:0] OP_IFST = 5'b10100;
   localparam logic [4:0] OP_IFGT = 5'b10101;

   localparam int OPC_HI   = 15;
   localparam int OPC_LO   = 11;
   localparam int PARAM_HI = 7;
   localparam int PARAM_LO = 0;

   typedef enum logic {
      ST_RUN       = 1'b0,
      ST_COND_WAIT = 1'b1
   } fetch_state_e;

   typedef enum logic [1:0] {
      PC_INC  = 2'd0,
      PC_SKIP = 2'd1,
      PC_JUMP = 2'd2
   } pc_kind_e;

   function automatic logic is_cond(input logic [4:0] opc);
      return (opc == OP_IFZ) || (opc == OP_IFNZ) || (opc == OP_IFEQ) ||
             (opc == OP_IFST) || (opc == OP_IFGT);
   endfunction

   function automatic logic cond_taken(input logic [4:0] opc, input logic zero,
                                       input logic eq, input logic st, input logic gt);
      logic taken;
      taken = 1'b0;
      case (opc)
         OP_IFZ:  taken = zero;
         OP_IFNZ: taken = !zero;
         OP_IFEQ: taken = eq;
         OP_IFST: taken = st;
         OP_IFGT: taken = gt;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-pc: increment, skip (pc+1+param) or jump (param),
// computed one bit wider so out-of-range targets fold back to 0.
module next_pc_calc
   import jac_isa_pkg::*;
#(
   parameter int PC_WIDTH = 8,
   parameter int CMD_CNT  = 64
) (
   input  logic [PC_WIDTH-1:0] pc_i,
   input  logic [PC_WIDTH-1:0] param_i,
   input  pc_kind_e            kind_i,
   output logic [PC_WIDTH-1:0] next_pc_o,
   output logic                wrap_o
);

   localparam logic [PC_WIDTH:0] PC_ONE = {{PC_WIDTH{1'b0}}, 1'b1};
   localparam logic [PC_WIDTH:0] LIMIT  = (PC_WIDTH + 1)'(CMD_CNT);

   logic [PC_WIDTH:0] sum_w;

   always_comb begin
      sum_w = {1'b0, pc_i} + PC_ONE;
      case (kind_i)
         PC_INC:  sum_w = {1'b0, pc_i} + PC_ONE;
         PC_SKIP: sum_w = {1'b0, pc_i} + {1'b0, param_i} + PC_ONE;
         PC_JUMP: sum_w = {1'b0, param_i};
         default: sum_w = {1'b0, pc_i} + PC_ONE;
      endcase
   end

   assign wrap_o    = (sum_w >= LIMIT);
   assign next_pc_o = wrap_o ? '0 : sum_w[PC_WIDTH-1:0];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/control-flow stage: resolves nop, goto and conditional skips locally
// and hands every other word to execute through a one-entry valid/ready slot.
module fetch_sequencer
   import jac_isa_pkg::*;
#(
   parameter int PC_WIDTH = 8,
   parameter int IRWidth  = 16,
   parameter int CMD_CNT  = 64
) (
   input  logic                clk,
   input  logic                res_n,
   output logic [PC_WIDTH-1:0] pc,
   input  logic [IRWidth-1:0]  ir,
   output logic [IRWidth-1:0]  instr,
   output logic                instr_valid,
   input  logic                instr_ready,
   input  logic                flags_valid,
   input  logic                flag_zero,
   input  logic                flag_eq,
   input  logic                flag_st,
   input  logic                flag_gt,
   input  logic                halt,
   output logic                pc_wrap
);

   fetch_state_e        state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [IRWidth-1:0]  instr_q, instr_d;
   logic                valid_q, valid_d;
   logic                wrap_q, wrap_d;

   logic [4:0]          opcode;
   logic [PC_WIDTH-1:0] param;
   logic                slot_free;
   logic                cond_ready;
   logic                taken;
   pc_kind_e            kind;
   logic [PC_WIDTH-1:0] npc;
   logic                npc_wrap;

   assign opcode     = ir[OPC_HI:OPC_LO];
   assign param      = ir[PARAM_LO +: PC_WIDTH];
   assign slot_free  = !valid_q || instr_ready;
   assign cond_ready = !valid_q && flags_valid;
   assign taken      = cond_taken(opcode, flag_zero, flag_eq, flag_st, flag_gt);

   // Kind depends only on the word and flags, keeping the pc adder out of the FSM loop.
   always_comb begin
      kind = PC_INC;
      if (opcode == OP_GOTO) begin
         kind = PC_JUMP;
      end else if (is_cond(opcode) && taken) begin
         kind = PC_SKIP;
      end
   end

   next_pc_calc #(
      .PC_WIDTH (PC_WIDTH),
      .CMD_CNT  (CMD_CNT)
   ) u_next_pc (
      .pc_i      (pc_q),
      .param_i   (param),
      .kind_i    (kind),
      .next_pc_o (npc),
      .wrap_o    (npc_wrap)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q && !instr_ready;
      wrap_d  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (!halt && slot_free) begin
               if (opcode == OP_GOTO || opcode == OP_NOP) begin
                  pc_d   = npc;
                  wrap_d = npc_wrap;
               end else if (is_cond(opcode)) begin
                  if (cond_ready) begin
                     pc_d   = npc;
                     wrap_d = npc_wrap;
                  end else begin
                     state_d = ST_COND_WAIT;
                  end
               end else begin
                  instr_d = ir;
                  valid_d = 1'b1;
                  pc_d    = npc;
                  wrap_d  = npc_wrap;
               end
            end
         end
         ST_COND_WAIT: begin
            // halt is deliberately ignored here; it only gates the following fetch.
            if (cond_ready) begin
               pc_d    = npc;
               wrap_d  = npc_wrap;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!res_n) begin
         state_q <= ST_RUN;
         pc_q    <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign pc_wrap     = wrap_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: small program memory model,
// directed pc checks and a scoreboard of issued instruction words.
module tb_fetch_sequencer;

   logic        clk;
   logic        res_n;
   logic [7:0]  pc;
   logic [15:0] ir;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        flags_valid;
   logic        flag_zero;
   logic        flag_eq;
   logic        flag_st;
   logic        flag_gt;
   logic        halt;
   logic        pc_wrap;

   logic [15:0] nvm [0:63];
   logic [15:0] sb [$];
   int          n_vec;
   int          n_err;

   assign ir = nvm[pc[5:0]];

   fetch_sequencer #(
      .PC_WIDTH (8),
      .IRWidth  (16),
      .CMD_CNT  (64)
   ) dut (
      .clk         (clk),
      .res_n       (res_n),
      .pc          (pc),
      .ir          (ir),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .flags_valid (flags_valid),
      .flag_zero   (flag_zero),
      .flag_eq     (flag_eq),
      .flag_st     (flag_st),
      .flag_gt     (flag_gt),
      .halt        (halt),
      .pc_wrap     (pc_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) nvm[i] = 16'h0000;
   endtask

   task automatic do_reset();
      res_n       = 1'b0;
      halt        = 1'b1;
      instr_ready = 1'b0;
      flags_valid = 1'b0;
      flag_zero   = 1'b0;
      flag_eq     = 1'b0;
      tick();
      tick();
      res_n = 1'b1;
   endtask

   // Every accepted word must match the oldest expected entry.
   always @(negedge clk) begin
      logic [15:0] e;
      if (res_n && instr_valid && instr_ready) begin
         e = (sb.size() > 0) ? sb.pop_front() : ~instr;
         check("sb_instr", 32'(instr), 32'(e));
      end
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      res_n = 1'b0;
      halt = 1'b1;
      instr_ready = 1'b0;
      flags_valid = 1'b0;
      flag_zero = 1'b0;
      flag_eq = 1'b0;
      flag_st = 1'b0;
      flag_gt = 1'b0;
      clear_mem();

      // reset state, then halt keeps pc at 0
      nvm[0] = 16'h4903;
      tick();
      check("rst_pc", 32'(pc), 32'h0);
      check("rst_valid", 32'(instr_valid), 32'h0);
      check("rst_instr", 32'(instr), 32'h0);
      check("rst_wrap", 32'(pc_wrap), 32'h0);
      res_n = 1'b1;
      tick();
      check("halt_pc", 32'(pc), 32'h0);
      check("halt_valid", 32'(instr_valid), 32'h0);

      // back-to-back issue
      do_reset();
      clear_mem();
      nvm[0] = 16'h4903; nvm[1] = 16'h2112; nvm[2] = 16'h8002;
      sb.push_back(16'h4903); sb.push_back(16'h2112);
      instr_ready = 1'b1; halt = 1'b0;
      tick();
      check("b2b_valid1", 32'(instr_valid), 32'h1);
      check("b2b_instr1", 32'(instr), 32'h4903);
      check("b2b_pc1", 32'(pc), 32'h1);
      tick();
      check("b2b_pc2", 32'(pc), 32'h2);
      check("b2b_instr2", 32'(instr), 32'h2112);
      check("b2b_valid2", 32'(instr_valid), 32'h1);
      tick();
      check("b2b_goto_pc", 32'(pc), 32'h2);
      check("b2b_drain", 32'(instr_valid), 32'h0);

      // backpressure holds instr and pc
      do_reset();
      clear_mem();
      nvm[0] = 16'h4A14; nvm[1] = 16'h2222; nvm[2] = 16'h8002;
      sb.push_back(16'h4A14); sb.push_back(16'h2222);
      halt = 1'b0;
      tick();
      check("bp_instr0", 32'(instr), 32'h4A14);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_hold_instr", 32'(instr), 32'h4A14);
         check("bp_hold_pc", 32'(pc), 32'h1);
      end
      instr_ready = 1'b1;
      tick();
      check("bp_next_instr", 32'(instr), 32'h2222);
      check("bp_next_pc", 32'(pc), 32'h2);
      check("bp_next_valid", 32'(instr_valid), 32'h1);
      tick();
      check("bp_drain", 32'(instr_valid), 32'h0);

      // ifz not taken / taken
      for (int z = 0; z < 2; z++) begin
         do_reset();
         clear_mem();
         nvm[0] = 16'h800A; nvm[10] = 16'h8802; nvm[11] = 16'h800B; nvm[13] = 16'h800D;
         halt = 1'b0; instr_ready = 1'b1; flags_valid = 1'b1; flag_zero = (z == 1);
         tick();
         check("ifz_at10", 32'(pc), 32'd10);
         tick();
         check("ifz_pc", 32'(pc), (z == 1) ? 32'd13 : 32'd11);
         check("ifz_noissue", 32'(instr_valid), 32'h0);
      end

      // ifeq waits for drain and flags
      do_reset();
      clear_mem();
      nvm[0] = 16'h8015; nvm[21] = 16'h3355; nvm[22] = 16'h9801; nvm[24] = 16'h8018;
      sb.push_back(16'h3355);
      halt = 1'b0; flag_eq = 1'b1;
      tick();
      tick();
      check("ifeq_issue_pc", 32'(pc), 32'd22);
      check("ifeq_issue_valid", 32'(instr_valid), 32'h1);
      tick();
      check("ifeq_hold_pc", 32'(pc), 32'd22);
      instr_ready = 1'b1;
      tick();
      check("ifeq_wait_pc", 32'(pc), 32'd22);
      check("ifeq_wait_valid", 32'(instr_valid), 32'h0);
      instr_ready = 1'b0;
      tick();
      check("ifeq_wait_pc2", 32'(pc), 32'd22);
      halt = 1'b1; flags_valid = 1'b1;
      tick();
      check("ifeq_taken_pc", 32'(pc), 32'd24);
      tick();
      check("ifeq_halt_pc", 32'(pc), 32'd24);

      // goto and wrap
      do_reset();
      clear_mem();
      nvm[0] = 16'h8020; nvm[32] = 16'h8008; nvm[8] = 16'h8046;
      halt = 1'b0; instr_ready = 1'b1;
      tick();
      check("goto_pc32", 32'(pc), 32'd32);
      tick();
      check("goto_pc8", 32'(pc), 32'd8);
      check("goto_valid", 32'(instr_valid), 32'h0);
      check("goto_nowrap", 32'(pc_wrap), 32'h0);
      tick();
      check("goto_wrap_pc", 32'(pc), 32'd0);
      check("goto_wrap", 32'(pc_wrap), 32'h1);
      tick();
      check("goto_wrap_once", 32'(pc_wrap), 32'h0);
      check("goto_again", 32'(pc), 32'd32);

      // increment past the last word wraps
      do_reset();
      clear_mem();
      nvm[0] = 16'h803F;
      halt = 1'b0;
      tick();
      check("inc_pc63", 32'(pc), 32'd63);
      tick();
      check("inc_wrap_pc", 32'(pc), 32'd0);
      check("inc_wrap", 32'(pc_wrap), 32'h1);

      // reset mid-handshake discards held word
      do_reset();
      clear_mem();
      nvm[0] = 16'h5A5A; nvm[1] = 16'h8001;
      halt = 1'b0;
      tick();
      check("mid_valid", 32'(instr_valid), 32'h1);
      res_n = 1'b0;
      tick();
      check("mid_rst_valid", 32'(instr_valid), 32'h0);
      check("mid_rst_instr", 32'(instr), 32'h0);
      check("mid_rst_pc", 32'(pc), 32'h0);

      // reset while in COND_WAIT returns to RUN
      do_reset();
      clear_mem();
      nvm[0] = 16'h8005; nvm[5] = 16'h9801;
      halt = 1'b0;
      tick();
      tick();
      check("cw_pc", 32'(pc), 32'd5);
      res_n = 1'b0; flags_valid = 1'b1; flag_eq = 1'b1;
      tick();
      check("cw_rst_pc", 32'(pc), 32'd0);
      res_n = 1'b1; halt = 1'b1; flags_valid = 1'b0;
      tick();
      check("cw_halt_pc", 32'(pc), 32'd0);
      clear_mem();
      nvm[0] = 16'h1234; nvm[1] = 16'h8001;
      sb.push_back(16'h1234);
      halt = 1'b0; instr_ready = 1'b1; flags_valid = 1'b1;
      tick();
      check("cw_run_valid", 32'(instr_valid), 32'h1);
      check("cw_run_instr", 32'(instr), 32'h1234);
      check("cw_run_pc", 32'(pc), 32'd1);
      tick();
      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
